// File: rtl/coleco_ctrl_responder_pkg.sv
// Shared types and constants for the ColecoVision controller responder:
// scan states, console select modes, key code map and small lookup helpers.
package coleco_ctrl_responder_pkg;

    typedef enum logic [1:0] {
        ROW0 = 2'd0,
        ROW1 = 2'd1,
        ROW2 = 2'd2,
        ROW3 = 2'd3
    } scan_state_t;

    // Synchronized {SEL_JOYn, SEL_KPDn}
    typedef enum logic [1:0] {
        MODE_IDLE_LO = 2'b00,
        MODE_JOY     = 2'b01,
        MODE_KPD     = 2'b10,
        MODE_IDLE_HI = 2'b11
    } sel_mode_t;

    localparam logic [3:0] KEY_1    = 4'hD;
    localparam logic [3:0] KEY_2    = 4'h7;
    localparam logic [3:0] KEY_3    = 4'hC;
    localparam logic [3:0] KEY_4    = 4'h2;
    localparam logic [3:0] KEY_5    = 4'h3;
    localparam logic [3:0] KEY_6    = 4'hE;
    localparam logic [3:0] KEY_7    = 4'h5;
    localparam logic [3:0] KEY_8    = 4'h1;
    localparam logic [3:0] KEY_9    = 4'hB;
    localparam logic [3:0] KEY_STAR = 4'h9;
    localparam logic [3:0] KEY_0    = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'h6;
    localparam logic [3:0] KEY_NONE = 4'hF;

    // Matrix position (row*3 + col) -> key code; nibble 0 is row0/col0.
    localparam logic [47:0] KEY_MAP = {
        KEY_HASH, KEY_0, KEY_STAR,
        KEY_9,    KEY_8, KEY_7,
        KEY_6,    KEY_5, KEY_4,
        KEY_3,    KEY_2, KEY_1
    };

    // Active-low row drive for a scan state.
    function automatic logic [3:0] row_select_n(input scan_state_t row);
        logic [3:0] sel_n;
        case (row)
            ROW0:    sel_n = 4'b1110;
            ROW1:    sel_n = 4'b1101;
            ROW2:    sel_n = 4'b1011;
            ROW3:    sel_n = 4'b0111;
            default: sel_n = 4'b1111;
        endcase
        return sel_n;
    endfunction

    // Code of the leftmost pressed column on the given row, KEY_NONE if none.
    function automatic logic [3:0] row_key_code(input scan_state_t row, input logic [2:0] col_n);
        logic [3:0] code;
        code = KEY_NONE;
        for (int c = 2; c >= 0; c--) begin
            if (!col_n[c]) begin
                code = KEY_MAP[(int'(row) * 3 + c) * 4 +: 4];
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/coleco_ctrl_responder_if.sv
// Console-facing controller port: select strobes from the console, data
// pins back to the console. master = console side, slave = controller side.
interface coleco_ctrl_responder_if;
    logic SEL_JOYn;
    logic SEL_KPDn;
    logic C_0;
    logic C_1;
    logic C_2;
    logic C_3;
    logic C_5;
    logic C_6;

    modport master (
        output SEL_JOYn, SEL_KPDn,
        input  C_0, C_1, C_2, C_3, C_5, C_6
    );

    modport slave (
        input  SEL_JOYn, SEL_KPDn,
        output C_0, C_1, C_2, C_3, C_5, C_6
    );
endinterface

// File: rtl/coleco_ctrl_responder_debounce.sv
// Two-flop synchronizer plus hold counter for one raw low-active switch.
// The stable level only moves after the synced input has disagreed with it
// for 2^DEBOUNCE_BITS consecutive cycles; counter wrap is the accept event.
module coleco_ctrl_responder_debounce #(
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic level_n
);

    logic                     raw_p0;
    logic                     raw_p1;
    logic [DEBOUNCE_BITS-1:0] hold_cnt;

    // Bring the asynchronous switch into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_p0 <= 1'b1;
            raw_p1 <= 1'b1;
        end else begin
            raw_p0 <= raw_n;
            raw_p1 <= raw_p0;
        end
    end

    // Count consecutive disagreement; accept the new level when the counter wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            level_n  <= 1'b1;
        end else if (raw_p1 == level_n) begin
            hold_cnt <= '0;
        end else if (hold_cnt == '1) begin
            level_n  <= raw_p1;
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/coleco_ctrl_responder.sv
// Controller-side responder for the ColecoVision hand-controller port.
// Debounces joystick/fire switches, scans the 4x3 keypad, and answers the
// console's joystick/keypad select strobes on registered data pins.
module coleco_ctrl_responder
    import coleco_ctrl_responder_pkg::*;
#(
    parameter int DEBOUNCE_BITS = 16,
    parameter int SCAN_DIV_BITS = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    coleco_ctrl_responder_if.slave   bus,
    input  logic                     JOY_UPn,
    input  logic                     JOY_DOWNn,
    input  logic                     JOY_LEFTn,
    input  logic                     JOY_RIGHTn,
    input  logic                     FIRE_Ln,
    input  logic                     FIRE_Rn,
    input  logic [2:0]               KPD_COLn,
    output logic [3:0]               KPD_ROWn
);

    // Discrete switches, index order: up, down, left, right, fire L, fire R.
    logic [5:0] sw_raw_n;
    logic [5:0] sw_lvl_n;

    assign sw_raw_n = {FIRE_Rn, FIRE_Ln, JOY_RIGHTn, JOY_LEFTn, JOY_DOWNn, JOY_UPn};

    for (genvar i = 0; i < 6; i++) begin : g_debounce
        coleco_ctrl_responder_debounce #(
            .DEBOUNCE_BITS(DEBOUNCE_BITS)
        ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .raw_n   (sw_raw_n[i]),
            .level_n (sw_lvl_n[i])
        );
    end

    logic sel_joyn_p0;
    logic sel_joyn_p1;
    logic sel_kpdn_p0;
    logic sel_kpdn_p1;

    // Select strobes come straight from the console; synchronize both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_joyn_p0 <= 1'b1;
            sel_joyn_p1 <= 1'b1;
            sel_kpdn_p0 <= 1'b1;
            sel_kpdn_p1 <= 1'b1;
        end else begin
            sel_joyn_p0 <= bus.SEL_JOYn;
            sel_joyn_p1 <= sel_joyn_p0;
            sel_kpdn_p0 <= bus.SEL_KPDn;
            sel_kpdn_p1 <= sel_kpdn_p0;
        end
    end

    scan_state_t              state;
    scan_state_t              state_next;
    logic [SCAN_DIV_BITS-1:0] dwell_cnt;
    logic                     dwell_last;
    logic [3:0]               row_n_next;

    // Scan state and free-running dwell counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ROW0;
            dwell_cnt <= '0;
        end else begin
            state     <= state_next;
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

    // Advance to the next row when the dwell counter is about to wrap.
    always_comb begin
        dwell_last = (dwell_cnt == '1);
        state_next = state;
        if (dwell_last) begin
            case (state)
                ROW0:    state_next = ROW1;
                ROW1:    state_next = ROW2;
                ROW2:    state_next = ROW3;
                ROW3:    state_next = ROW0;
                default: state_next = ROW0;
            endcase
        end
        row_n_next = row_select_n(state_next);
    end

    logic [2:0] col_n_p0;
    logic [2:0] col_n_p1;

    // Row drive follows the scan state; column returns are synchronized.
    // Rows are registered so reset can float them all high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            KPD_ROWn <= 4'b1111;
            col_n_p0 <= 3'b111;
            col_n_p1 <= 3'b111;
        end else begin
            KPD_ROWn <= row_n_next;
            col_n_p0 <= KPD_COLn;
            col_n_p1 <= col_n_p0;
        end
    end

    logic [3:0] row_code;
    logic [3:0] scan_sel;
    logic [3:0] scan_acc;
    logic [3:0] prev_cand;
    logic [3:0] key_code;

    // First pressed key in scan order wins; row0 starts a fresh scan.
    always_comb begin
        row_code = row_key_code(state, col_n_p1);
        scan_sel = scan_acc;
        if (state == ROW0 || scan_acc == KEY_NONE) begin
            scan_sel = row_code;
        end
    end

    // Accumulate per row; publish the key only when two whole scans agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_acc  <= KEY_NONE;
            prev_cand <= KEY_NONE;
            key_code  <= KEY_NONE;
        end else if (dwell_last) begin
            scan_acc <= scan_sel;
            if (state == ROW3) begin
                prev_cand <= scan_sel;
                if (scan_sel == prev_cand) begin
                    key_code <= scan_sel;
                end
            end
        end
    end

    sel_mode_t  mode;
    logic [5:0] pins_next;   // {C_6, C_5, C_3, C_2, C_1, C_0}

    // Mode mux: joystick levels, keypad nibble, or all released when idle.
    always_comb begin
        mode      = sel_mode_t'({sel_joyn_p1, sel_kpdn_p1});
        pins_next = 6'b111111;
        case (mode)
            MODE_JOY: pins_next = {1'b1, sw_lvl_n[4], sw_lvl_n[3], sw_lvl_n[2],
                                   sw_lvl_n[1], sw_lvl_n[0]};
            MODE_KPD: pins_next = {1'b1, sw_lvl_n[5], key_code[1], key_code[3],
                                   key_code[2], key_code[0]};
            default:  pins_next = 6'b111111;
        endcase
    end

    // Register the console data pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.C_6 <= 1'b1;
            bus.C_5 <= 1'b1;
            bus.C_3 <= 1'b1;
            bus.C_2 <= 1'b1;
            bus.C_1 <= 1'b1;
            bus.C_0 <= 1'b1;
        end else begin
            bus.C_6 <= pins_next[5];
            bus.C_5 <= pins_next[4];
            bus.C_3 <= pins_next[3];
            bus.C_2 <= pins_next[2];
            bus.C_1 <= pins_next[1];
            bus.C_0 <= pins_next[0];
        end
    end

endmodule
